fp_round_pack: RTL and testbench
================================

FP_ROUND_PACK -- requirements
Module: fp_round_pack

Interface
REQ-001 Parameter EXP_W, default 11, SHALL set the exponent field width; BIAS = 2^(EXP_W-1)-1, EMIN = 1-BIAS, EMAX = BIAS.
REQ-002 Parameter MAN_W, default 52, SHALL set the stored-fraction width; output word width FP_W = 1+EXP_W+MAN_W.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  input beat present.
REQ-006 in_ready  out  1  block accepts beat this cycle.
REQ-007 in_sign  in  1  result sign.
REQ-008 in_exp  in  EXP_W+2  signed unbiased exponent of in_man MSB.
REQ-009 in_man  in  MAN_W+4  {hidden, fraction, guard, round, sticky}; hidden=1 unless in_zero.
REQ-010 in_rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf).
REQ-011 in_nan, in_inf, in_zero  in  1 each  special-value overrides; priority nan > inf > zero.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 out_fp  out  FP_W  packed IEEE-754 result.
REQ-015 out_flags  out  4  {invalid-unused=0, overflow, underflow, inexact}.

Function
REQ-016 Block SHALL be a 2-stage pipeline (S1 denormalise, S2 round+pack); latency exactly 2 cycles from accepted input to out_valid when out_ready stays high.
REQ-017 Each stage SHALL hold a valid bit; a stage loads when empty or when the stage downstream advances; in_ready = !s1_valid || s1_advance.
REQ-018 Beat transfers SHALL occur only when valid && ready on the same edge; out_fp/out_flags SHALL stay stable while out_valid && !out_ready.
REQ-019 Throughput SHALL be one beat per cycle with out_ready held high; no bubbles inserted.
REQ-020 S1: if in_exp < EMIN, mantissa SHALL be right-shifted by EMIN-in_exp, shift saturated at MAN_W+3, shifted-out bits ORed into sticky; biased exponent forced to 0 (tiny).
REQ-021 S2 rounding increment: RNE = G && (R||S||lsb); RTZ = 0; RUP = !sign && (G||R||S); RDN = sign && (G||R||S).
REQ-022 inexact SHALL equal G||R||S after denormalisation.
REQ-023 Mantissa carry-out from rounding SHALL increment the exponent and clear the fraction; a tiny value rounding to hidden=1 SHALL pack with biased exponent 1.
REQ-024 Overflow (rounded exponent > EMAX): RNE, or RUP with sign=0, or RDN with sign=1 -> +/-inf; otherwise max finite (exponent all-ones-minus-1, fraction all ones); overflow=1, inexact=1.
REQ-025 underflow SHALL be 1 only when the result is tiny after rounding and inexact.
REQ-026 in_nan SHALL output canonical quiet NaN {0, all-ones exp, 1, zeros}, flags 0; in_inf -> {sign, all-ones, 0}; in_zero -> {sign, 0, 0}; special flags 0.
REQ-027 Simultaneous input accept and output drain SHALL not lose or duplicate a beat.

Reset
REQ-028 On rst_n low: s1_valid, s2_valid, out_valid = 0, out_fp = 0, out_flags = 0, in_ready = 1 from the first cycle after release.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no partial output after release.

Structure
REQ-030 Rounding-mode encodings, flag bit indices and canonical-NaN builder function SHALL live in shared package fp_pkg.
REQ-031 S2 rounding/overflow logic SHALL be sub-module fp_round_core (combinational, parametrised by EXP_W, MAN_W).

Verification (default parameters)
REQ-032 exp=0, man=1.0 exact, RNE -> 0x3FF0000000000000, flags 0, 2 cycles.
REQ-033 exp=0, frac all ones, G=1, RNE -> 0x4000000000000000, inexact=1; tie G=1 R=S=0 lsb=0 -> 0x3FF0000000000000 inexact=1.
REQ-034 exp=1023, frac all ones, G=1: RNE -> 0x7FF0000000000000 overflow=1; RTZ -> 0x7FEFFFFFFFFFFFFF overflow=1.
REQ-035 exp=-1023, man=1.0 exact -> 0x0008000000000000, underflow=0; exp=-1100 -> 0, underflow=1, inexact=1; same with RUP -> 0x0000000000000001.
REQ-036 Stream 4 beats, out_ready low 3 cycles mid-stream -> in_ready drops after 2 held beats, outputs in order, none lost.
REQ-037 rst_n asserted with 2 beats in flight -> out_valid 0, no stale output after release; in_nan -> 0x7FF8000000000000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared encodings for the floating-point round/pack path: rounding modes,
// flag bit positions and the canonical quiet-NaN builder.
package fp_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rm_e;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_W         = 4;

    localparam int FP_MAX_W = 128;

    // Quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in a wide word.
    function automatic logic [FP_MAX_W-1:0] canonical_nan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] w;
        w = '0;
        for (int i = 0; i < exp_w; i++) begin
            w[man_w + i] = 1'b1;
        end
        w[man_w - 1] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/fp_round_core.sv
// Round, overflow/underflow detection and final packing of a denormalised
// mantissa with a biased exponent. Purely combinational.
module fp_round_core
    import fp_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                    sign,
    input  logic signed [EXP_W+2:0] exp_b,
    input  logic [MAN_W+3:0]        man,
    input  logic [1:0]              rm,
    input  logic                    is_nan,
    input  logic                    is_inf,
    input  logic                    is_zero,
    output logic [EXP_W+MAN_W:0]    fp,
    output logic [FLAG_W-1:0]       flags
);

    localparam int FP_W = 1 + EXP_W + MAN_W;
    localparam int EB_W = EXP_W + 3;
    localparam logic signed [EB_W-1:0] E_ONE = EB_W'(1);
    localparam logic signed [EB_W-1:0] E_INF = EB_W'((1 << EXP_W) - 1);
    localparam logic [FP_W-1:0]        QNAN  = FP_W'(canonical_nan(EXP_W, MAN_W));

    function automatic logic round_inc(input rm_e mode, input logic s, input logic lsb,
                                       input logic g, input logic r, input logic st);
        case (mode)
            RM_RNE:  return g && (r || st || lsb);
            RM_RTZ:  return 1'b0;
            RM_RUP:  return !s && (g || r || st);
            default: return s && (g || r || st);
        endcase
    endfunction

    // Carry-out bumps the exponent; a tiny value that rounds up into the
    // hidden position becomes the smallest normal.
    function automatic logic signed [EB_W-1:0] round_exp(input logic signed [EB_W-1:0] e,
                                                          input logic [MAN_W+1:0] m);
        if (m[MAN_W+1]) return e + E_ONE;
        if (e == '0 && m[MAN_W]) return E_ONE;
        return e;
    endfunction

    rm_e                    mode;
    logic                   g, r, st, lsb, inexact, inc, inc_near, ovf, to_inf;
    logic [MAN_W+1:0]       sum, sum_near;
    logic signed [EB_W-1:0] exp_r;

    always_comb begin
        mode     = rm_e'(rm);
        lsb      = man[3];
        g        = man[2];
        r        = man[1];
        st       = man[0];
        inexact  = g | r | st;
        inc      = round_inc(mode, sign, lsb, g, r, st);
        inc_near = round_inc(RM_RNE, sign, lsb, g, r, st);
        sum      = {1'b0, man[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, inc};
        sum_near = {1'b0, man[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, inc_near};
        exp_r    = round_exp(exp_b, sum);
        // Overflow also counts when the value reaches the threshold under
        // nearest rounding, even if the selected mode truncates back to max finite.
        ovf      = (exp_r >= E_INF) || (round_exp(exp_b, sum_near) >= E_INF);
        to_inf   = (mode == RM_RNE) || (mode == RM_RUP && !sign) || (mode == RM_RDN && sign);

        fp                    = {sign, exp_r[EXP_W-1:0], sum[MAN_W-1:0]};
        flags                 = '0;
        flags[FLAG_INVALID]   = 1'b0;
        flags[FLAG_INEXACT]   = inexact;
        flags[FLAG_UNDERFLOW] = (exp_r == '0) && inexact;

        if (ovf) begin
            fp = to_inf ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                        : {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            flags[FLAG_OVERFLOW]  = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
            flags[FLAG_UNDERFLOW] = 1'b0;
        end

        if (is_nan) begin
            fp    = QNAN;
            flags = '0;
        end else if (is_inf) begin
            fp    = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags = '0;
        end else if (is_zero) begin
            fp    = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            flags = '0;
        end
    end

endmodule

// File: rtl/fp_round_pack.sv
// Two-stage round-and-pack pipeline: S1 denormalises tiny values into the
// subnormal range, S2 rounds and packs into an IEEE-754 word.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W+1:0] in_exp,
    input  logic [MAN_W+3:0]        in_man,
    input  logic [1:0]              in_rm,
    input  logic                    in_nan,
    input  logic                    in_inf,
    input  logic                    in_zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MAN_W:0]    out_fp,
    output logic [FLAG_W-1:0]       out_flags
);

    localparam int FP_W = 1 + EXP_W + MAN_W;
    localparam int EB_W = EXP_W + 3;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EB_W-1:0] BIAS_E   = EB_W'(BIAS);
    localparam logic signed [EB_W-1:0] EMIN_E   = EB_W'(1 - BIAS);
    localparam logic signed [EB_W-1:0] SH_MAX_E = EB_W'(MAN_W + 3);

    // Right shift with every bit pushed past the sticky position folded into it.
    function automatic logic [MAN_W+3:0] denorm(input logic [MAN_W+3:0] m,
                                                input logic [EB_W-1:0] sh);
        logic [MAN_W+3:0] lost;
        logic [MAN_W+3:0] kept;
        lost = m & ~({(MAN_W+4){1'b1}} << sh);
        kept = m >> sh;
        return {kept[MAN_W+3:1], kept[0] | (|lost)};
    endfunction

    logic                   s1_valid, s2_valid, s2_ready;
    logic signed [EB_W-1:0] exp_ext, shift_amt, exp_p0;
    logic                   tiny;
    logic [MAN_W+3:0]       man_p0;

    logic                   sign_p1, nan_p1, inf_p1, zero_p1;
    logic [1:0]             rm_p1;
    logic signed [EB_W-1:0] exp_p1;
    logic [MAN_W+3:0]       man_p1;

    logic [FP_W-1:0]        round_fp;
    logic [FLAG_W-1:0]      round_flags;

    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign out_valid = s2_valid;

    // ---- S1: denormalise ----
    always_comb begin
        exp_ext   = EB_W'(in_exp);
        tiny      = exp_ext < EMIN_E;
        shift_amt = EMIN_E - exp_ext;
        if (shift_amt > SH_MAX_E) shift_amt = SH_MAX_E;
        man_p0    = tiny ? denorm(in_man, shift_amt) : in_man;
        exp_p0    = tiny ? '0 : exp_ext + BIAS_E;
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            sign_p1 <= in_sign;
            exp_p1  <= exp_p0;
            man_p1  <= man_p0;
            rm_p1   <= in_rm;
            nan_p1  <= in_nan;
            inf_p1  <= in_inf;
            zero_p1 <= in_zero;
        end
    end

    // ---- S2: round and pack ----
    fp_round_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign    (sign_p1),
        .exp_b   (exp_p1),
        .man     (man_p1),
        .rm      (rm_p1),
        .is_nan  (nan_p1),
        .is_inf  (inf_p1),
        .is_zero (zero_p1),
        .fp      (round_fp),
        .flags   (round_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_fp    <= '0;
            out_flags <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_fp    <= round_fp;
                    out_flags <= round_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: table of hand-derived vectors checked through a
// scoreboard, plus latency, back-pressure and mid-flight reset sequences.
module tb_fp_round_pack;

    localparam int EXP_W = 11;
    localparam int MAN_W = 52;
    localparam int NV    = 24;

    localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;
    localparam logic [55:0] M_ONE   = 56'h80000000000000;
    localparam logic [55:0] M_ALL_G = 56'hFFFFFFFFFFFFFC;
    localparam logic [55:0] M_TIE0  = 56'h80000000000004;
    localparam logic [55:0] M_TIE1  = 56'h8000000000000C;
    localparam logic [55:0] M_S     = 56'h80000000000001;
    localparam logic [3:0]  F_X = 4'b0001, F_UX = 4'b0011, F_OX = 4'b0101;

    logic                    clk, rst_n, in_valid, in_ready, in_sign;
    logic                    in_nan, in_inf, in_zero, out_valid, out_ready;
    logic signed [EXP_W+1:0] in_exp;
    logic [MAN_W+3:0]        in_man;
    logic [1:0]              in_rm;
    logic [63:0]             out_fp;
    logic [3:0]              out_flags;

    typedef struct packed {
        logic               sign;
        logic signed [12:0] e;
        logic [55:0]        man;
        logic [1:0]         rm;
        logic [2:0]         spec;
        logic [63:0]        fp;
        logic [3:0]         flags;
    } vec_t;

    typedef struct packed {
        logic [15:0] id;
        logic [63:0] fp;
        logic [3:0]  flags;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .in_rm     (in_rm),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input int e, input logic [55:0] m,
                                input logic [1:0] rm, input logic [2:0] spec,
                                input logic [63:0] fp, input logic [3:0] fl);
        vec_t v;
        v.sign = s; v.e = 13'(e); v.man = m; v.rm = rm;
        v.spec = spec; v.fp = fp; v.flags = fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out: got fp=%h flags=%b, required no output", out_fp, out_flags);
                end else begin
                    e = sb[0];
                    chk($sformatf("vec%0d {fp,flags}", e.id), {out_fp, out_flags}, {e.fp, e.flags});
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    endtask

    task automatic send(input vec_t v, input int id);
        int   guard;
        logic accepted;
        exp_t e;
        guard    = 0;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_sign  = v.sign;
        in_exp   = v.e;
        in_man   = v.man;
        in_rm    = v.rm;
        {in_nan, in_inf, in_zero} = v.spec;
        while (!accepted && guard <= 100) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            else begin
                guard++;
                @(posedge clk); #1;
            end
        end
        if (accepted) begin
            e.id = 16'(id); e.fp = v.fp; e.flags = v.flags;
            sb.push_back(e);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout vec%0d: in_ready got 0, required 1", id);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = mk(0,     0, M_ONE,   RNE, 3'b000, 64'h3FF0000000000000, 4'b0000);
        vecs[1]  = mk(0,     0, M_ALL_G, RNE, 3'b000, 64'h4000000000000000, F_X);
        vecs[2]  = mk(0,     0, M_TIE0,  RNE, 3'b000, 64'h3FF0000000000000, F_X);
        vecs[3]  = mk(0,  1023, M_ALL_G, RNE, 3'b000, 64'h7FF0000000000000, F_OX);
        vecs[4]  = mk(0,  1023, M_ALL_G, RTZ, 3'b000, 64'h7FEFFFFFFFFFFFFF, F_OX);
        vecs[5]  = mk(0, -1023, M_ONE,   RNE, 3'b000, 64'h0008000000000000, 4'b0000);
        vecs[6]  = mk(0, -1100, M_ONE,   RNE, 3'b000, 64'h0000000000000000, F_UX);
        vecs[7]  = mk(0, -1100, M_ONE,   RUP, 3'b000, 64'h0000000000000001, F_UX);
        vecs[8]  = mk(1,     0, M_ONE,   RNE, 3'b100, 64'h7FF8000000000000, 4'b0000);
        vecs[9]  = mk(1,     0, M_ONE,   RNE, 3'b010, 64'hFFF0000000000000, 4'b0000);
        vecs[10] = mk(1,     0, M_ONE,   RNE, 3'b001, 64'h8000000000000000, 4'b0000);
        vecs[11] = mk(1,     0, M_ONE,   RNE, 3'b111, 64'h7FF8000000000000, 4'b0000);
        vecs[12] = mk(0,     0, M_ONE,   RNE, 3'b011, 64'h7FF0000000000000, 4'b0000);
        vecs[13] = mk(1,     0, M_TIE0,  RDN, 3'b000, 64'hBFF0000000000001, F_X);
        vecs[14] = mk(1,     0, M_TIE0,  RUP, 3'b000, 64'hBFF0000000000000, F_X);
        vecs[15] = mk(0,     0, M_S,     RTZ, 3'b000, 64'h3FF0000000000000, F_X);
        vecs[16] = mk(0,     0, M_TIE1,  RNE, 3'b000, 64'h3FF0000000000002, F_X);
        vecs[17] = mk(0,  1023, M_ALL_G, RDN, 3'b000, 64'h7FEFFFFFFFFFFFFF, F_OX);
        vecs[18] = mk(1,  1023, M_ALL_G, RUP, 3'b000, 64'hFFEFFFFFFFFFFFFF, F_OX);
        vecs[19] = mk(1,  1023, M_ALL_G, RDN, 3'b000, 64'hFFF0000000000000, F_OX);
        vecs[20] = mk(0,  1024, M_ONE,   RTZ, 3'b000, 64'h7FEFFFFFFFFFFFFF, F_OX);
        vecs[21] = mk(0, -1023, M_ALL_G, RNE, 3'b000, 64'h0010000000000000, F_X);
        vecs[22] = mk(0, -1074, M_ONE,   RNE, 3'b000, 64'h0000000000000001, 4'b0000);
        vecs[23] = mk(0, -1075, M_ONE,   RNE, 3'b000, 64'h0000000000000000, F_UX);

        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_sign = 1'b0;
        in_exp = '0; in_man = '0; in_rm = RNE; in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 72'(out_valid), 72'(0));
        chk("rst_out_fp",    72'(out_fp),    72'(0));
        chk("rst_out_flags", 72'(out_flags), 72'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 72'(in_ready), 72'(1));

        fork
            monitor();
        join_none

        // Two-cycle latency with an idle pipeline
        @(posedge clk); #1;
        send(vecs[0], 0);
        chk("latency_cycle1_out_valid", 72'(out_valid), 72'(0));
        @(posedge clk); #1;
        chk("latency_cycle2_out_valid", 72'(out_valid), 72'(1));
        drain();

        // Full table, back to back
        for (int i = 0; i < NV; i++) send(vecs[i], i);
        drain();

        // Back-pressure: out_ready low for three cycles mid-stream
        fork
            begin
                for (int i = 0; i < 4; i++) send(vecs[i + 1], i + 1);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready",  72'(in_ready),  72'(0));
                chk("stall_out_valid", 72'(out_valid), 72'(1));
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(vecs[1], 1);
        send(vecs[2], 2);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", 72'(out_valid), 72'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_out_valid", 72'(out_valid), 72'(0));
        end
        @(posedge clk); #1;
        send(vecs[8], 8);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
